jedro_1_dmem_ws: RTL and testbench
==================================

// Module: jedro_1_dmem_ws
// PURPOSE
//  Parametrised byte-writable data RAM slave for the jedro_1 data port (stb/we/addr/wdata -> rdata/ack/err).
//  Generalises the fixed single-cycle byte-write RAM wrapper with configurable width, depth, base address and wait states.
//  Adds bus-error signalling for out-of-range and misaligned accesses.
//  Sits between jedro_1_top dram_* ports and the bench/SoC, letting benches stress LSU stall handling.
// PARAMETERS
//  DATA_WIDTH   32    word width in bits; multiple of 8, power of two
//  ADDR_WIDTH   32    byte-address width
//  DEPTH        1024  number of words; power of two
//  BASE_ADDR    0     byte address of word 0; DEPTH*DATA_WIDTH/8-aligned
//  WAIT_STATES  0     extra cycles between acceptance and response (0..15)
// PORTS
//  clk_i    in   1             clock, all logic on rising edge
//  rst_i    in   1             synchronous reset, active high
//  stb_i    in   1             request strobe
//  we_i     in   DATA_WIDTH/8  byte write enables; all-zero = read
//  addr_i   in   ADDR_WIDTH    byte address
//  wdata_i  in   DATA_WIDTH    write data, lane i = wdata_i[8i+7:8i]
//  rdata_o  out  DATA_WIDTH    read data, valid in ack_o cycle of a read
//  ack_o    out  1             one-cycle pulse: request completed OK
//  err_o    out  1             one-cycle pulse: request rejected
//  busy_o   out  1             high while a request is outstanding
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, rdata_o=0, ack_o=0, err_o=0, busy_o=0. RAM contents are not reset.
//  Storage: array named RAM, DEPTH x DATA_WIDTH; bench reads RAM[k] hierarchically.
//  Word index k = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  IDLE:
//   - stb_i=1 accepts the request: latch addr/we/wdata, set busy_o=1.
//   - Next state is WAIT if WAIT_STATES>0, else RESP.
//  WAIT: count WAIT_STATES cycles, then RESP.
//  RESP (one cycle):
//   - Memory op performed on entry edge; ack_o or err_o high for this single cycle.
//   - busy_o stays 1 through RESP.
//   - Next state always IDLE.
//  Latency: request accepted at edge t -> ack_o/err_o high in cycle t+1+WAIT_STATES.
//  Throughput: at most one request per WAIT_STATES+2 cycles.
//  stb_i while busy_o=1 is ignored; it is not queued and the master must re-present it.
//  Error conditions (err_o=1, no RAM write, rdata_o unchanged):
//   - Misaligned: addr[log2(DATA_WIDTH/8)-1:0] != 0.
//   - Out of range: addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH*DATA_WIDTH/8.
//  Write (we_i != 0):
//   - Only lanes with we_i[i]=1 are updated; other lanes keep old data.
//   - rdata_o unchanged.
//  Read: rdata_o <= RAM[k], held until the next successful read or reset.
//  ack_o and err_o are never high in the same cycle; neither is ever high while busy_o=0.
//  Reset mid-transaction: aborts immediately, no RAM write, no ack_o/err_o; next cycle is IDLE.
//  Last address (k = DEPTH-1) is valid; no wrap-around.
// TESTING
//  T1 reset: rst_i=1 for 3 cycles -> ack_o=err_o=busy_o=0, rdata_o=0.
//  T2 sw/lw, WAIT_STATES=0: write 0x0000000D to 0x0 and 0x4 with we=4'hF, then read 0x4
//     -> ack_o one cycle after each accept; RAM[0]=RAM[1]=0x0000000D; rdata_o=0x0000000D.
//  T3 byte lanes: RAM[2]=0xAABBCCDD, write 0x11223344 to 0x8 with we=4'b0101 -> RAM[2]=0xAA22CC44.
//  T4 wait states, WAIT_STATES=3: read accepted at edge t -> ack_o only in cycle t+4, busy_o 1 for t+1..t+4.
//     Second stb_i at t+2 is ignored: exactly one ack_o.
//  T5 errors, DEPTH=1024, BASE_ADDR=0:
//     addr=0x2 -> err_o;
//     addr=0x1000 -> err_o;
//     addr=0xFFC -> ack_o.
//     No RAM change after erroring writes.
//  T6 reset mid-op, WAIT_STATES=2: assert rst_i one cycle after a write is accepted
//     -> no ack_o/err_o, target word unchanged, next request completes normally.

Source files
------------

// File: rtl/jedro_1_dmem_ws.sv
// jedro_1_dmem_ws: byte-writable data RAM slave for the jedro_1 data port.
// One request is accepted at a time. After WAIT_STATES idle cycles the
// response cycle raises ack_o (success) or err_o (misaligned or out-of-range
// address). The memory operation itself happens on the clock edge that enters
// the response cycle.
module jedro_1_dmem_ws #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH       = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    stb_i,
   input  logic [DATA_WIDTH/8-1:0] we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    busy_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFS  = $clog2(BYTES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Size of the mapped window in bytes; one extra bit so the top never overflows.
   localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH * BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [3:0]            WS_LAST    = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   logic [DATA_WIDTH-1:0] RAM [DEPTH];

   state_t                state;
   logic [3:0]            wcnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BYTES-1:0]      we_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [BYTES-1:0]      req_we;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      req_idx;
   logic                  req_ok;
   logic                  accept;
   logic                  do_op;

   // Pick the request being served: live inputs when responding straight out of
   // IDLE, latched copy when coming out of WAIT; decode range, alignment, index.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      req_addr  = addr_q;
      req_we    = we_q;
      req_wdata = wdata_q;
      if (state == S_IDLE) begin
         req_addr  = addr_i;
         req_we    = we_i;
         req_wdata = wdata_i;
      end
      offset  = req_addr - BASE_ADDR;
      req_idx = offset[OFFS +: IDX_W];
      req_ok  = (req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN)
                && ((req_addr & ALIGN_MASK) == '0);
      accept  = (state == S_IDLE) && stb_i;
      do_op   = !rst_i && ((accept && (WAIT_STATES == 0))
                           || ((state == S_WAIT) && (wcnt == WS_LAST)));
   end

   // Byte-lane writes into the storage array on the edge entering RESP.
   always_ff @(posedge clk_i) begin
      // NOTE: the array has no reset; clearing a RAM would forbid block-RAM mapping.
      if (do_op && req_ok) begin
         for (int i = 0; i < BYTES; i++) begin
            if (req_we[i]) RAM[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   // Request capture register, loaded whenever a strobe is accepted in IDLE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         we_q    <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= addr_i;
         we_q    <= we_i;
         wdata_q <= wdata_i;
      end
   end

   // Control FSM with registered ack/err/busy/rdata outputs.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      if (rst_i) begin
         state   <= S_IDLE;
         wcnt    <= '0;
         rdata_o <= '0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         if (do_op) begin
            state  <= S_RESP;
            busy_o <= 1'b1;
            if (req_ok) begin
               ack_o <= 1'b1;
               if (req_we == '0) rdata_o <= RAM[req_idx];
            end else begin
               err_o <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (stb_i) begin
                     state  <= S_WAIT;
                     wcnt   <= '0;
                     busy_o <= 1'b1;
                  end
               end
               S_WAIT:  wcnt <= wcnt + 4'd1;
               S_RESP: begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jedro_1_dmem_ws.sv
// Bench for jedro_1_dmem_ws: three instances (0, 3 and 2 wait states, the last
// one mapped at 0x2000), a vector table, hand-written multi-cycle sequences and
// a randomized phase checked against a byte-addressed memory model.
module tb_jedro_1_dmem_ws;

   logic        clk = 1'b0;
   logic        rst     [3];
   logic        stb     [3];
   logic [3:0]  we      [3];
   logic [31:0] addr    [3];
   logic [31:0] wdata   [3];
   logic [31:0] rdata_w [3];
   logic        ack_w   [3];
   logic        err_w   [3];
   logic        busy_w  [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   jedro_1_dmem_ws #(.WAIT_STATES(0), .BASE_ADDR(32'h0)) d0 (
      .clk_i(clk), .rst_i(rst[0]), .stb_i(stb[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .rdata_o(rdata_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]),
      .busy_o(busy_w[0]));
   jedro_1_dmem_ws #(.WAIT_STATES(3), .BASE_ADDR(32'h0)) d3 (
      .clk_i(clk), .rst_i(rst[1]), .stb_i(stb[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .rdata_o(rdata_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]),
      .busy_o(busy_w[1]));
   jedro_1_dmem_ws #(.WAIT_STATES(2), .BASE_ADDR(32'h2000)) d2 (
      .clk_i(clk), .rst_i(rst[2]), .stb_i(stb[2]), .we_i(we[2]), .addr_i(addr[2]),
      .wdata_i(wdata[2]), .rdata_o(rdata_w[2]), .ack_o(ack_w[2]), .err_o(err_w[2]),
      .busy_o(busy_w[2]));

   // ---------------- reference model: byte-addressed window per instance ----
   logic [7:0]  m_byte  [3][4096];
   bit          m_known [3][4096];
   logic [31:0] m_rd    [3];
   logic [31:0] m_mask  [3];

   function automatic int ws_of(input int idx);
      return (idx == 0) ? 0 : (idx == 1) ? 3 : 2;
   endfunction

   function automatic logic [31:0] base_of(input int idx);
      return (idx == 2) ? 32'h2000 : 32'h0;
   endfunction

   function automatic logic [31:0] ram_word(input int idx, input int k);
      case (idx)
         0:       return d0.RAM[k];
         1:       return d3.RAM[k];
         default: return d2.RAM[k];
      endcase
   endfunction

   function automatic logic [31:0] known_mask(input int idx, input int off);
      logic [31:0] m = '0;
      for (int i = 0; i < 4; i++) if (m_known[idx][off+i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [31:0] model_word(input int idx, input int off);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = m_byte[idx][off+i];
      return w;
   endfunction

   task automatic model_reset(input int idx);
      m_rd[idx]   = '0;
      m_mask[idx] = '1;
   endtask

   task automatic model_req(input int idx, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, output bit e_ack, output bit e_err);
      longint off = longint'({32'd0, a}) - longint'({32'd0, base_of(idx)});
      if ((a % 4) != 0 || off < 0 || off >= 4096) begin
         e_ack = 1'b0;
         e_err = 1'b1;
         return;
      end
      e_ack = 1'b1;
      e_err = 1'b0;
      if (w != 4'h0) begin
         for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
               m_byte[idx][int'(off)+i]  = d[8*i +: 8];
               m_known[idx][int'(off)+i] = 1'b1;
            end
         end
      end else begin
         m_rd[idx]   = model_word(idx, int'(off));
         m_mask[idx] = known_mask(idx, int'(off));
      end
   endtask

   // ---------------- checking helpers -------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One bus transaction: present for one edge, then wait (bounded) for the response.
   task automatic do_req(input int idx, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, output logic got_ack, output logic got_err,
                         output logic [31:0] got_rd, output int lat);
      bit busy_ok = 1'b1;
      bit excl_ok = 1'b1;
      bit done    = 1'b0;
      @(negedge clk);
      check($sformatf("i%0d idle before req", idx),
            {61'd0, ack_w[idx], err_w[idx], busy_w[idx]}, 64'd0);
      stb[idx] = 1'b1; we[idx] = w; addr[idx] = a; wdata[idx] = d;
      @(posedge clk);
      #1;
      stb[idx] = 1'b0; we[idx] = 4'h0;
      got_ack = 1'b0; got_err = 1'b0; got_rd = '0; lat = -1;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         if (busy_w[idx] !== 1'b1) busy_ok = 1'b0;
         if (ack_w[idx] === 1'b1 && err_w[idx] === 1'b1) excl_ok = 1'b0;
         if (ack_w[idx] === 1'b1 || err_w[idx] === 1'b1) begin
            got_ack = ack_w[idx]; got_err = err_w[idx]; got_rd = rdata_w[idx];
            lat = c; done = 1'b1;
         end
      end
      check($sformatf("i%0d busy through req", idx), 64'(busy_ok), 64'd1);
      check($sformatf("i%0d ack/err exclusive", idx), 64'(excl_ok), 64'd1);
      check($sformatf("i%0d latency a=%0h", idx, a), 64'(lat), 64'(1 + ws_of(idx)));
   endtask

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_ack;
      bit          exp_err;
      logic [31:0] exp_rd;
      int          chk_k;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic        ga, ge, ea, ee;
      logic [31:0] grd;
      int          lat;

      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; stb[i] = 1'b0; we[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
         model_reset(i);
      end

      // T2 / T3 / T5 vectors on the zero-wait instance
      vecs[0]  = '{4'hF, 32'h0,    32'h0000000D, 1, 0, 32'h0,        0,    32'h0000000D};
      vecs[1]  = '{4'hF, 32'h4,    32'h0000000D, 1, 0, 32'h0,        1,    32'h0000000D};
      vecs[2]  = '{4'h0, 32'h4,    32'h0,        1, 0, 32'h0000000D, 0,    32'h0000000D};
      vecs[3]  = '{4'hF, 32'h8,    32'hAABBCCDD, 1, 0, 32'h0000000D, 2,    32'hAABBCCDD};
      vecs[4]  = '{4'h5, 32'h8,    32'h11223344, 1, 0, 32'h0000000D, 2,    32'hAA22CC44};
      vecs[5]  = '{4'h0, 32'h8,    32'h0,        1, 0, 32'hAA22CC44, 1,    32'h0000000D};
      vecs[6]  = '{4'hF, 32'h2,    32'hFFFFFFFF, 0, 1, 32'hAA22CC44, 0,    32'h0000000D};
      vecs[7]  = '{4'h0, 32'h1000, 32'h0,        0, 1, 32'hAA22CC44, -1,   32'h0};
      vecs[8]  = '{4'hF, 32'h1000, 32'hFFFFFFFF, 0, 1, 32'hAA22CC44, 0,    32'h0000000D};
      vecs[9]  = '{4'hF, 32'hFFC,  32'h12345678, 1, 0, 32'hAA22CC44, 1023, 32'h12345678};
      vecs[10] = '{4'h0, 32'hFFC,  32'h0,        1, 0, 32'h12345678, 1023, 32'h12345678};
      vecs[11] = '{4'h0, 32'h2,    32'h0,        0, 1, 32'h12345678, 2,    32'hAA22CC44};

      // T1 reset
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("i%0d reset ack", i),   64'(ack_w[i]),   64'd0);
         check($sformatf("i%0d reset err", i),   64'(err_w[i]),   64'd0);
         check($sformatf("i%0d reset busy", i),  64'(busy_w[i]),  64'd0);
         check($sformatf("i%0d reset rdata", i), 64'(rdata_w[i]), 64'd0);
      end

      // Vector table
      for (int v = 0; v < 12; v++) begin
         do_req(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, ga, ge, grd, lat);
         model_req(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, ea, ee);
         check($sformatf("vec%0d ack", v),   64'(ga),  64'(vecs[v].exp_ack));
         check($sformatf("vec%0d err", v),   64'(ge),  64'(vecs[v].exp_err));
         check($sformatf("vec%0d rdata", v), 64'(grd), 64'(vecs[v].exp_rd));
         if (vecs[v].chk_k >= 0)
            check($sformatf("vec%0d RAM[%0d]", v, vecs[v].chk_k),
                  64'(ram_word(0, vecs[v].chk_k)), 64'(vecs[v].exp_word));
      end

      // T4: three wait states, a stray strobe while busy must be dropped
      do_req(1, 4'hF, 32'h0, 32'hCAFEF00D, ga, ge, grd, lat);
      model_req(1, 4'hF, 32'h0, 32'hCAFEF00D, ea, ee);
      check("t4 setup ack", 64'(ga), 64'd1);
      @(negedge clk);
      stb[1] = 1'b1; we[1] = 4'h0; addr[1] = 32'h0;
      @(posedge clk);
      #1;
      stb[1] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check($sformatf("t4 ack c%0d", c),  64'(ack_w[1]),  64'(c == 4));
         check($sformatf("t4 busy c%0d", c), 64'(busy_w[1]), 64'(c <= 4));
         check($sformatf("t4 err c%0d", c),  64'(err_w[1]),  64'd0);
         if (c == 2) stb[1] = 1'b1;
         if (c == 3) stb[1] = 1'b0;
      end
      model_req(1, 4'h0, 32'h0, 32'h0, ea, ee);
      check("t4 rdata", 64'(rdata_w[1]), 64'(32'hCAFEF00D));

      // T6: reset one cycle after a write is accepted (two wait states, base 0x2000)
      do_req(2, 4'hF, 32'h2010, 32'h5A5A5A5A, ga, ge, grd, lat);
      model_req(2, 4'hF, 32'h2010, 32'h5A5A5A5A, ea, ee);
      check("t6 setup ack", 64'(ga), 64'd1);
      do_req(2, 4'h0, 32'h1FFC, 32'h0, ga, ge, grd, lat);
      model_req(2, 4'h0, 32'h1FFC, 32'h0, ea, ee);
      check("t6 below base err", 64'(ge), 64'd1);
      @(negedge clk);
      stb[2] = 1'b1; we[2] = 4'hF; addr[2] = 32'h2010; wdata[2] = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      stb[2] = 1'b0; we[2] = 4'h0; rst[2] = 1'b1;
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      model_reset(2);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("t6 no resp c%0d", c), {62'd0, ack_w[2], err_w[2]}, 64'd0);
         check($sformatf("t6 idle c%0d", c), 64'(busy_w[2]), 64'd0);
      end
      check("t6 word kept", 64'(ram_word(2, 4)), 64'(32'h5A5A5A5A));
      check("t6 rdata reset", 64'(rdata_w[2]), 64'd0);
      do_req(2, 4'h0, 32'h2010, 32'h0, ga, ge, grd, lat);
      model_req(2, 4'h0, 32'h2010, 32'h0, ea, ee);
      check("t6 next ack", 64'(ga), 64'd1);
      check("t6 next rdata", 64'(grd), 64'(32'h5A5A5A5A));

      // Randomized phase against the model
      for (int n = 0; n < 180; n++) begin
         int          idx = n % 3;
         int          r   = $urandom_range(0, 9);
         logic [31:0] b   = base_of(idx);
         logic [31:0] a;
         logic [3:0]  w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
         logic [31:0] d   = $urandom();
         if (r <= 5)      a = b + 32'(4 * $urandom_range(0, 15));
         else if (r == 6) a = b + 32'hFFC;
         else if (r == 7) a = b + 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
         else if (r == 8) a = b + 32'h1000 + 32'(4 * $urandom_range(0, 255));
         else if (idx == 2) a = b - 32'(4 * $urandom_range(1, 16));
         else             a = ($urandom() | 32'h8000_0000) & ~32'h3;
         do_req(idx, w, a, d, ga, ge, grd, lat);
         model_req(idx, w, a, d, ea, ee);
         check($sformatf("rnd%0d ack a=%0h", n, a), 64'(ga), 64'(ea));
         check($sformatf("rnd%0d err a=%0h", n, a), 64'(ge), 64'(ee));
         check($sformatf("rnd%0d rdata a=%0h", n, a),
               64'(grd & m_mask[idx]), 64'(m_rd[idx] & m_mask[idx]));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Final sweep of the touched words
      for (int idx = 0; idx < 3; idx++) begin
         for (int k = 0; k <= 16; k++) begin
            int          kk = (k == 16) ? 1023 : k;
            logic [31:0] m  = known_mask(idx, 4 * kk);
            if (m != '0)
               check($sformatf("sweep i%0d RAM[%0d]", idx, kk),
                     64'(ram_word(idx, kk) & m), 64'(model_word(idx, 4 * kk) & m));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
